// File: rtl/tlp_tx_arbiter_pkg.sv
// Shared definitions for the TRN TX path: arbiter FSM state encoding, TLP
// format/type codes, and the round-robin distance helper.
// No ports (package).
package tlp_tx_arbiter_pkg;

  localparam int unsigned IDX_W = 3;  // width of requester index fields
  localparam int unsigned CNT_W = 5;  // width of the grant timeout counter

  // One-hot arbiter states.
  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StGrant = 4'b0010,
    StBusy  = 4'b0100,
    StGap   = 4'b1000
  } tx_state_e;

  // TLP header fmt field.
  localparam logic [1:0] TLP_FMT_3DW_NODATA = 2'b00;
  localparam logic [1:0] TLP_FMT_4DW_NODATA = 2'b01;
  localparam logic [1:0] TLP_FMT_3DW_DATA   = 2'b10;
  localparam logic [1:0] TLP_FMT_4DW_DATA   = 2'b11;

  // TLP header type field.
  localparam logic [4:0] TLP_TYPE_MEM = 5'b00000;
  localparam logic [4:0] TLP_TYPE_IO  = 5'b00010;
  localparam logic [4:0] TLP_TYPE_CFG = 5'b00100;
  localparam logic [4:0] TLP_TYPE_CPL = 5'b01010;

  // Round-robin distance of cand after last (1..n); the smallest wins.
  function automatic int unsigned rr_dist(input int unsigned cand, input int unsigned last,
                                          input int unsigned n);
    return (cand > last) ? (cand - last) : (cand + n - last);
  endfunction

endpackage

// File: rtl/tlp_tx_arbiter_rr_pick.sv
// Combinational round-robin picker (rr_pick).
// Ports:
//   i_req   - per-requester request vector
//   i_last  - index of the last served requester
//   o_idx   - first requesting index after i_last, wrapping NUM_REQ-1 -> 0
//   o_valid - at least one request is present
module tlp_tx_arbiter_rr_pick
  import tlp_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  always_comb begin
    int unsigned best;
    o_idx   = '0;
    o_valid = 1'b0;
    best    = NUM_REQ + 1;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (i_req[i] && (rr_dist(i, 32'(i_last), NUM_REQ) < best)) begin
        best    = rr_dist(i, 32'(i_last), NUM_REQ);
        o_idx   = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlp_tx_arbiter.sv
// Round-robin arbiter handing the TRN TX interface to one of NUM_REQ
// requesters. A grant is held until the grantee takes over (driving_interface)
// or GRANT_TIMEOUT cycles pass; after release one dead GAP cycle is inserted.
// Ports:
//   trn_clk, reset       - clock, synchronous active-high reset
//   req_ep               - per-requester level request
//   driving_interface    - per-requester "owns TX interface" flag
//   my_turn              - registered one-hot grant
//   grant_idx            - index of current or last grantee
//   tx_busy              - high in GRANT or BUSY
//   timeout_err          - one-cycle pulse when a grant times out
//   overlap_err          - sticky: a non-grantee drove the interface
module tlp_tx_arbiter
  import tlp_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned GRANT_TIMEOUT = 16
) (
  input  logic               trn_clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_ep,
  input  logic [NUM_REQ-1:0] driving_interface,
  output logic [NUM_REQ-1:0] my_turn,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               tx_busy,
  output logic               timeout_err,
  output logic               overlap_err
);

  tx_state_e          r_state,       w_state_nxt;
  logic [NUM_REQ-1:0] r_my_turn,     w_my_turn_nxt;
  logic [IDX_W-1:0]   r_grant_idx,   w_grant_idx_nxt;
  logic [IDX_W-1:0]   r_last_grant,  w_last_grant_nxt;
  logic [CNT_W-1:0]   r_cnt,         w_cnt_nxt;
  logic               r_timeout_err, w_timeout_err_nxt;
  logic               r_overlap_err, w_overlap_err_nxt;

  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_valid;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [NUM_REQ-1:0] w_grant_mask;
  logic               w_grant_drv;
  logic               w_other_drv;

  tlp_tx_arbiter_rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .i_req  (req_ep),
    .i_last (r_last_grant),
    .o_idx  (w_pick_idx),
    .o_valid(w_pick_valid)
  );

  // Decode indices into masks with compares so no narrow-vector indexing by
  // a 3-bit index is needed for small NUM_REQ.
  always_comb begin
    w_pick_onehot = '0;
    w_grant_mask  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_pick_onehot[i] = (w_pick_idx == IDX_W'(i));
      w_grant_mask[i]  = (r_grant_idx == IDX_W'(i));
    end
  end

  assign w_grant_drv = |(driving_interface & w_grant_mask);
  assign w_other_drv = |(driving_interface & ~w_grant_mask);

  always_comb begin
    w_state_nxt       = r_state;
    w_my_turn_nxt     = r_my_turn;
    w_grant_idx_nxt   = r_grant_idx;
    w_last_grant_nxt  = r_last_grant;
    w_cnt_nxt         = r_cnt;
    w_timeout_err_nxt = 1'b0;
    w_overlap_err_nxt = r_overlap_err;

    unique case (r_state)
      StIdle: begin
        w_my_turn_nxt = '0;
        if (|driving_interface) w_overlap_err_nxt = 1'b1;
        if (w_pick_valid) begin
          w_state_nxt     = StGrant;
          w_my_turn_nxt   = w_pick_onehot;
          w_grant_idx_nxt = w_pick_idx;
          w_cnt_nxt       = '0;
        end
      end
      StGrant: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_other_drv) w_overlap_err_nxt = 1'b1;
        // Takeover wins over a timeout landing on the same cycle.
        if (w_grant_drv) begin
          w_state_nxt   = StBusy;
          w_my_turn_nxt = '0;
        end else if (r_cnt == CNT_W'(GRANT_TIMEOUT - 1)) begin
          w_state_nxt       = StIdle;
          w_my_turn_nxt     = '0;
          w_timeout_err_nxt = 1'b1;
          w_last_grant_nxt  = r_grant_idx;
        end
      end
      StBusy: begin
        w_my_turn_nxt = '0;
        if (w_other_drv) w_overlap_err_nxt = 1'b1;
        if (!w_grant_drv) begin
          w_state_nxt      = StGap;
          w_last_grant_nxt = r_grant_idx;
        end
      end
      StGap: begin
        // Bus turnaround: never grant here.
        w_my_turn_nxt = '0;
        w_state_nxt   = StIdle;
      end
      default: begin
        w_my_turn_nxt = '0;
        w_state_nxt   = StIdle;
      end
    endcase
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      r_state       <= StIdle;
      r_my_turn     <= '0;
      r_grant_idx   <= '0;
      r_last_grant  <= IDX_W'(NUM_REQ - 1);  // requester 0 wins first
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
      r_overlap_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_my_turn     <= w_my_turn_nxt;
      r_grant_idx   <= w_grant_idx_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_cnt         <= w_cnt_nxt;
      r_timeout_err <= w_timeout_err_nxt;
      r_overlap_err <= w_overlap_err_nxt;
    end
  end

  assign my_turn     = r_my_turn;
  assign grant_idx   = r_grant_idx;
  assign tx_busy     = (r_state == StGrant) || (r_state == StBusy);
  assign timeout_err = r_timeout_err;
  assign overlap_err = r_overlap_err;

endmodule
